// File: rtl/hfg_norm_pkg.sv
// rtl/hfg_norm_pkg.sv - shared defaults and coefficient constants for the feature normalizer
package hfg_norm_pkg;

   localparam int DEF_IN_W       = 21;
   localparam int DEF_OUT_W      = 32;
   localparam int DEF_COEF_W     = 16;
   localparam int DEF_NUM_SCALES = 8;
   localparam int DEF_FRAC_SHIFT = 6;

   // 14570/64 ~= 227.66, the 17x17 window normalization factor
   localparam int NORM_COEF_17X17 = 14570;

   typedef logic [DEF_COEF_W-1:0] coef_t;

endpackage

// File: rtl/hfg_norm_coef_table.sv
// rtl/hfg_norm_coef_table.sv - per-scale coefficient register file with guarded access
module hfg_norm_coef_table
   import hfg_norm_pkg::*;
#(
   parameter int COEF_W     = DEF_COEF_W,
   parameter int NUM_SCALES = DEF_NUM_SCALES,
   parameter int SEL_W      = $clog2(NUM_SCALES)
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              wr,
   input  logic [SEL_W-1:0]  wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [SEL_W-1:0]  rd_addr,
   output logic [COEF_W-1:0] rd_data
);

   logic [COEF_W-1:0] tbl [NUM_SCALES];

   logic wr_in_range;
   logic rd_in_range;

   assign wr_in_range = (32'(wr_addr) < NUM_SCALES);
   assign rd_in_range = (32'(rd_addr) < NUM_SCALES);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_SCALES; i++) begin
            tbl[i] <= COEF_W'(NORM_COEF_17X17);
         end
      end else if (wr && wr_in_range) begin
         tbl[wr_addr] <= wr_data;
      end
   end

   // Combinational read returns the pre-write value during a same-cycle write
   assign rd_data = rd_in_range ? tbl[rd_addr] : '0;

endmodule

// File: rtl/hfg_feature_normalizer.sv
// rtl/hfg_feature_normalizer.sv - 3-stage sign-magnitude scale/shift/saturate normalizer
module hfg_feature_normalizer
   import hfg_norm_pkg::*;
#(
   parameter int IN_W       = DEF_IN_W,
   parameter int OUT_W      = DEF_OUT_W,
   parameter int COEF_W     = DEF_COEF_W,
   parameter int NUM_SCALES = DEF_NUM_SCALES,
   parameter int FRAC_SHIFT = DEF_FRAC_SHIFT,
   parameter int SEL_W      = $clog2(NUM_SCALES)
) (
   input  logic              iClk,
   input  logic              iReset_n,
   input  logic              iValid,
   output logic              oReady,
   input  logic [IN_W-1:0]   iPre_Feature,
   input  logic [SEL_W-1:0]  iScale_Sel,
   input  logic              iCoef_Wr,
   input  logic [SEL_W-1:0]  iCoef_Addr,
   input  logic [COEF_W-1:0] iCoef_Data,
   output logic              oValid,
   input  logic              iReady,
   output logic [OUT_W-1:0]  oFeature,
   output logic [SEL_W-1:0]  oScale_Sel,
   output logic              oSat
);

   localparam int PW = IN_W + COEF_W;
   localparam int WW = (PW > OUT_W) ? PW : OUT_W;
   localparam logic [WW-1:0] MAX_POS = WW'({(OUT_W-1){1'b1}});

   logic              advance;
   logic [COEF_W-1:0] coef_rd;
   logic [IN_W-1:0]   in_mag;

   logic              s1_valid;
   logic [IN_W-1:0]   s1_mag;
   logic              s1_sign;
   logic [COEF_W-1:0] s1_coef;
   logic [SEL_W-1:0]  s1_sel;

   logic              s2_valid;
   logic [PW-1:0]     s2_prod;
   logic              s2_sign;
   logic [SEL_W-1:0]  s2_sel;

   logic [WW-1:0]     q_wide;
   logic              q_sat;
   logic [OUT_W-1:0]  q_mag;
   logic [OUT_W-1:0]  q_signed;

   // The whole pipe moves as one; internal bubbles are kept rather than squeezed out
   assign advance = ~oValid | iReady;
   assign oReady  = advance;

   hfg_norm_coef_table #(
      .COEF_W     (COEF_W),
      .NUM_SCALES (NUM_SCALES),
      .SEL_W      (SEL_W)
   ) u_coef_table (
      .clk     (iClk),
      .reset_n (iReset_n),
      .wr      (iCoef_Wr),
      .wr_addr (iCoef_Addr),
      .wr_data (iCoef_Data),
      .rd_addr (iScale_Sel),
      .rd_data (coef_rd)
   );

   // Unsigned magnitude: the most negative input maps cleanly onto 2^(IN_W-1)
   assign in_mag = iPre_Feature[IN_W-1] ? (-iPre_Feature) : iPre_Feature;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         s1_valid <= 1'b0;
         s1_mag   <= '0;
         s1_sign  <= 1'b0;
         s1_coef  <= '0;
         s1_sel   <= '0;
      end else if (advance) begin
         s1_valid <= iValid;
         if (iValid) begin
            s1_mag  <= in_mag;
            s1_sign <= iPre_Feature[IN_W-1];
            s1_coef <= coef_rd;
            s1_sel  <= iScale_Sel;
         end
      end
   end

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         s2_valid <= 1'b0;
         s2_prod  <= '0;
         s2_sign  <= 1'b0;
         s2_sel   <= '0;
      end else if (advance) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_prod <= PW'(s1_mag) * PW'(s1_coef);
            s2_sign <= s1_sign;
            s2_sel  <= s1_sel;
         end
      end
   end

   // Truncating the magnitude rounds toward zero for either sign
   assign q_wide   = WW'(s2_prod >> FRAC_SHIFT);
   assign q_sat    = (q_wide > MAX_POS);
   assign q_mag    = q_sat ? MAX_POS[OUT_W-1:0] : q_wide[OUT_W-1:0];
   assign q_signed = s2_sign ? (-q_mag) : q_mag;

   always_ff @(posedge iClk) begin
      if (!iReset_n) begin
         oValid     <= 1'b0;
         oFeature   <= '0;
         oSat       <= 1'b0;
         oScale_Sel <= '0;
      end else if (advance) begin
         oValid <= s2_valid;
         if (s2_valid) begin
            oFeature   <= q_signed;
            oSat       <= q_sat;
            oScale_Sel <= s2_sel;
         end
      end
   end

endmodule

// File: tb/tb_hfg_feature_normalizer.sv
// tb/tb_hfg_feature_normalizer.sv - directed self-checking bench for the feature normalizer
module tb_hfg_feature_normalizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rstn;

   logic        a_valid, a_oready, a_wr, a_ovalid, a_ready, a_sat;
   logic [20:0] a_data;
   logic [2:0]  a_sel, a_waddr, a_osel;
   logic [15:0] a_wdata;
   logic [31:0] a_feature;

   logic        b_valid, b_oready, b_wr, b_ovalid, b_ready, b_sat;
   logic [20:0] b_data;
   logic [2:0]  b_sel, b_waddr, b_osel;
   logic [15:0] b_wdata;
   logic [23:0] b_feature;

   int n_checks = 0;
   int n_fail   = 0;

   hfg_feature_normalizer dut_a (
      .iClk(clk), .iReset_n(rstn), .iValid(a_valid), .oReady(a_oready),
      .iPre_Feature(a_data), .iScale_Sel(a_sel), .iCoef_Wr(a_wr),
      .iCoef_Addr(a_waddr), .iCoef_Data(a_wdata), .oValid(a_ovalid),
      .iReady(a_ready), .oFeature(a_feature), .oScale_Sel(a_osel), .oSat(a_sat)
   );

   hfg_feature_normalizer #(.NUM_SCALES(6), .OUT_W(24)) dut_b (
      .iClk(clk), .iReset_n(rstn), .iValid(b_valid), .oReady(b_oready),
      .iPre_Feature(b_data), .iScale_Sel(b_sel), .iCoef_Wr(b_wr),
      .iCoef_Addr(b_waddr), .iCoef_Data(b_wdata), .oValid(b_ovalid),
      .iReady(b_ready), .oFeature(b_feature), .oScale_Sel(b_osel), .oSat(b_sat)
   );

   task automatic chk(input string tag, input longint obs, input longint exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      a_valid = 1'b0;
      a_wr    = 1'b0;
      b_valid = 1'b0;
      b_wr    = 1'b0;
   endtask

   task automatic put_a(input longint v, input int sel);
      a_valid = 1'b1;
      a_data  = v[20:0];
      a_sel   = sel[2:0];
   endtask

   task automatic put_b(input longint v, input int sel);
      b_valid = 1'b1;
      b_data  = v[20:0];
      b_sel   = sel[2:0];
   endtask

   task automatic chk_a(input string tag, input longint f, input longint s);
      chk({tag, ".valid"}, a_ovalid, 1);
      chk({tag, ".feat"}, $signed(a_feature), f);
      chk({tag, ".sat"}, a_sat, s);
   endtask

   task automatic chk_b(input string tag, input longint f, input longint s);
      chk({tag, ".valid"}, b_ovalid, 1);
      chk({tag, ".feat"}, $signed(b_feature), f);
      chk({tag, ".sat"}, b_sat, s);
   endtask

   function automatic longint model(input longint v, input longint c);
      longint m;
      longint q;
      m = (v < 0) ? -v : v;
      q = (m * c) / 64;
      return (v < 0) ? -q : q;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int  rd;
      int  wr;
      int  cyc;
      logic acc;
      logic pop;

      a_valid = 0; a_data = '0; a_sel = '0; a_wr = 0; a_waddr = '0; a_wdata = '0; a_ready = 1;
      b_valid = 0; b_data = '0; b_sel = '0; b_wr = 0; b_waddr = '0; b_wdata = '0; b_ready = 1;
      rstn = 1'b0;
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rstn = 1'b1;

      chk("rst.valid", a_ovalid, 0);
      chk("rst.feat", a_feature, 0);
      chk("rst.sat", a_sat, 0);
      chk("rst.sel", a_osel, 0);
      chk("rst.ready", a_oready, 1);

      // Default coefficient, four back-to-back samples
      put_a(100, 0);      tick();
      put_a(-100, 0);     tick();
      chk("t1.early", a_ovalid, 0);
      put_a(0, 0);        tick();
      chk_a("t1.pos", 22765, 0);
      put_a(-1048576, 0); tick();
      chk_a("t1.neg", -22765, 0);
      tick();
      chk_a("t1.zero", 0, 0);
      tick();
      chk_a("t1.min", -238714880, 0);
      tick();
      chk("t1.empty", a_ovalid, 0);

      // Stream 1..20 under random back-pressure
      rd = 0; wr = 0; cyc = 0;
      while (rd < 20 && cyc < 400) begin
         a_ready = 1'($urandom_range(0, 1));
         if (wr < 20) put_a(wr + 1, (wr + 1) % 4);
         #1;
         if (a_ovalid) begin
            chk("stream.feat", $signed(a_feature), model(rd + 1, 14570));
            chk("stream.sel", a_osel, (rd + 1) % 4);
            if (!a_ready) chk("stream.stall_ready", a_oready, 0);
         end
         acc = a_valid & a_oready;
         pop = a_ovalid & a_ready;
         tick();
         if (acc) wr++;
         if (pop) rd++;
         cyc++;
      end
      chk("stream.received", rd, 20);
      chk("stream.sent", wr, 20);
      a_ready = 1'b1;
      tick();
      chk("stream.drained", a_ovalid, 0);

      // Table write then per-scale selection
      a_wr = 1'b1; a_waddr = 3'd3; a_wdata = 16'hFFFF; tick();
      put_a(64, 3); tick();
      put_a(64, 0); tick();
      tick();
      chk_a("t2.sel3", 65535, 0);
      chk("t2.osel3", a_osel, 3);
      tick();
      chk_a("t2.sel0", 14570, 0);

      // Same-cycle write and accept on index 2
      a_wr = 1'b1; a_waddr = 3'd2; a_wdata = 16'd1000;
      put_a(64, 2); tick();
      put_a(64, 2); tick();
      tick();
      chk_a("t5.old", 14570, 0);
      tick();
      chk_a("t5.new", 1000, 0);

      // Narrow output, saturation and out-of-range select
      b_wr = 1'b1; b_waddr = 3'd0; b_wdata = 16'hFFFF; tick();
      put_b(1048575, 0);  tick();
      put_b(-1048575, 0); tick();
      put_b(1000, 0);     tick();
      chk_b("t3.possat", 8388607, 1);
      put_b(64, 7);       tick();
      chk_b("t3.negsat", -8388607, 1);
      tick();
      chk_b("t3.nosat", 1023984, 0);
      tick();
      chk_b("t3.oor", 0, 0);
      chk("t3.oor_sel", b_osel, 7);

      // Reset with samples in flight
      put_a(100, 0); tick();
      put_a(200, 0); tick();
      put_a(300, 0); tick();
      rstn = 1'b0;
      tick();
      chk("t6.valid", a_ovalid, 0);
      chk("t6.feat", a_feature, 0);
      chk("t6.sat", a_sat, 0);
      chk("t6.sel", a_osel, 0);
      rstn = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t6.no_stale", a_ovalid, 0);
      end
      put_a(64, 2); tick();
      put_a(64, 3); tick();
      tick();
      chk_a("t6.tbl2", 14570, 0);
      tick();
      chk_a("t6.tbl3", 14570, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/hfg_feature_normalizer.md
# hfg_feature_normalizer

Parametrised, pipelined normalizer for signed Haar pre-feature sums. Each accepted sample is scaled by a per-window-scale coefficient from a run-time-writable table, then truncated, saturated and re-signed. Sits between the Haar feature accumulator and the classifier stage comparators, and serves all detection window sizes from one instance. Uses a valid/ready handshake with back-pressure and a saturation flag.

## Interface
- IN_W, 21: signed pre-feature width (two's complement).
- OUT_W, 32: signed output feature width.
- COEF_W, 16: unsigned coefficient width.
- NUM_SCALES, 8: coefficient table depth (window scales); ≥2.
- FRAC_SHIFT, 6: right shift applied to the magnitude product.
- SEL_W, $clog2(NUM_SCALES): scale select width (derived).
- iClk, in, 1: the single clock; all logic on its rising edge.
- iReset_n, in, 1: reset, synchronous and active-low.
- iValid, in, 1: input sample valid.
- oReady, out, 1: block accepts a sample this cycle.
- iPre_Feature, in, IN_W: signed pre-feature.
- iScale_Sel, in, SEL_W: table index for this sample.
- iCoef_Wr, in, 1: coefficient write strobe.
- iCoef_Addr, in, SEL_W: write index.
- iCoef_Data, in, COEF_W: write data.
- oValid, out, 1: output valid.
- iReady, in, 1: downstream accepts output.
- oFeature, out, OUT_W: signed normalized feature.
- oScale_Sel, out, SEL_W: scale index travelling with the sample.
- oSat, out, 1: this output was saturated.

## Operation
- Pipeline of 3 stages (S1 magnitude/sign/coef fetch, S2 multiply, S3 shift/saturate/re-sign), each stage a register set with its own valid bit.
- advance = ~oValid | iReady; oReady = advance. All stages move together when advance=1; all hold when advance=0. Bubbles inside the pipe are not collapsed.
- Sample accepted when iValid & oReady.
- S1: mag = |iPre_Feature| as unsigned IN_W bits (−2^(IN_W−1) gives 2^(IN_W−1), no overflow); sign = MSB; coef = table[iScale_Sel]. Table is read at acceptance; later table writes do not affect in-flight samples.
- S2: prod = mag × coef, unsigned IN_W+COEF_W bits, exact.
- S3: q = prod >> FRAC_SHIFT (truncation of magnitude, i.e. rounds toward zero for both signs). If q > 2^(OUT_W−1)−1: q = 2^(OUT_W−1)−1, oSat=1. oFeature = sign ? −q : q. Zero input gives 0 with either sign.
- Coefficient table: NUM_SCALES × COEF_W registers. Write on iCoef_Wr, independent of handshake and stall. Write and acceptance of the same index in the same cycle: the sample uses the old value. The new value is used from the next cycle.
- Out-of-range iScale_Sel or iCoef_Addr (≥ NUM_SCALES): reads return 0; writes are ignored.
- Reset: every table entry is set to NORM_COEF_17X17 = 14570. This gives the ×227.66 17×17 normalization (14570/64).

## Timing
- Latency: 3 cycles from acceptance to oValid, with no stall.
- Throughput: 1 sample/cycle while iReady=1.
- oValid & ~iReady: oFeature, oSat and oScale_Sel are held stable, oReady=0, and no input is accepted.
- Reset values: oValid=0, oFeature=0, oSat=0, oScale_Sel=0. All internal valid bits are 0.
- Reset mid-operation: in-flight samples are discarded. The first output after reset comes from a sample accepted after iReset_n deasserts.
- A coefficient write in cycle t applies to samples accepted in cycle t+1 or later.

## Structure
- Package hfg_norm_pkg:
  - defaults IN_W/OUT_W/COEF_W/NUM_SCALES/FRAC_SHIFT
  - NORM_COEF_17X17 = 14570
  - coef_t typedef
- Sub-module hfg_norm_coef_table: register file with reset init, synchronous write, combinational read, and out-of-range guarding.
- Top module holds the 3-stage datapath and the stall logic.

## Test plan
- Defaults, reset coefficient, iReady=1: inputs 100, −100, 0, −1048576 -> 22765, −22765, 0, −238714880 at 3, 4, 5, 6 cycles after the first accept. oSat=0 for all.
- Write table[3]=65535, then send 64 with sel=3 and 64 with sel=0 back-to-back -> 65535 then 14570. Out-of-range sel=7 with NUM_SCALES=6 -> 0.
- OUT_W=24, coef 65535: input 1048575 -> 8388607 with oSat=1. Input −1048575 -> −8388607 with oSat=1. Input 1000 -> 1023984 with oSat=0.
- Continuous stream of 1..20 with iReady toggled pseudo-randomly:
  - every output matches the model, in order, with no loss or duplication;
  - outputs stay stable while oValid & ~iReady.
- Write table[2]=1000 in the same cycle a sel=2 sample is accepted -> that sample uses the old coefficient; the next sel=2 sample uses 1000.
- Assert iReset_n=0 for one cycle with 3 samples in flight:
  - outputs go to 0 / oValid=0 the next cycle;
  - no stale sample emerges;
  - the table returns to 14570.
